mux_arb_n: RTL and testbench
============================

# mux_arb_n

Parametrised N-channel, BUS_WIDTH-wide registered multiplexer with per-channel valid/ready handshakes and built-in arbitration. It replaces hand-selected 2:1 select muxes wherever several requesters share one consumer, such as instruction-fetch vs. load/store access to a shared memory port. The select is generated internally by a fixed-priority or round-robin arbiter. The winning word is captured in a single output register stage.

## Interface
- BUS_WIDTH, 32, data width of every channel and of the output
- NUM_CH, 4, number of input channels; legal range 2..16
- ARB_MODE, ARB_RR, arbitration mode: ARB_FIXED (lowest index wins) or ARB_RR (round robin)
- SEL_W, $clog2(NUM_CH), width of out_sel; derived, not overridden
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  NUM_CH*BUS_WIDTH  channel k occupies bits [k*BUS_WIDTH +: BUS_WIDTH]
- in_valid  input  NUM_CH  per-channel request
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero
- out_data  output  BUS_WIDTH  registered winning word
- out_valid  output  1  out_data holds an unconsumed word
- out_sel  output  SEL_W  index of the channel that produced out_data
- out_ready  input  1  consumer accepts out_data

## Operation
- Output register is "free" when !out_valid || out_ready.
- When the register is free and any in_valid is high, the arbiter picks winner w:
  - in_ready[w] = 1 combinationally; all other in_ready bits are 0.
  - On the clock edge, out_data <= in_data[w], out_sel <= w, out_valid <= 1.
- When the register is free and no in_valid is high: in_ready = 0. On the edge, out_valid <= 0; out_data and out_sel hold.
- When the register is not free (out_valid && !out_ready): in_ready = 0, and all output state holds.
- in_ready may depend on in_valid. in_valid never depends on in_ready.
- Producers keep in_valid and in_data stable until accepted. Dropping in_valid before acceptance is a protocol violation; the block has no defined behaviour for it.
- ARB_FIXED: w is the lowest index with in_valid set.
- ARB_RR: pointer p (SEL_W bits) gives the highest-priority index. Search order is p, p+1, ..., wrapping modulo NUM_CH.
  - After a grant to w, p <= (w+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  - p is unchanged on cycles without a grant.
  - A continuously requesting channel waits at most NUM_CH-1 grants.
- Simultaneous out_ready and new grant in the same cycle: the old word is consumed and the new word loaded on the same edge. No bubble.

## Timing
- Reset values, asynchronous on rst_n low: out_valid=0, out_data=0, out_sel=0, p=0. in_ready is forced 0 while rst_n is low.
- Reset mid-transfer discards the registered word. Producers observe no acceptance in the reset cycle.
- Latency: input accepted in cycle n appears on out_data/out_valid in cycle n+1.
- Throughput: one word per cycle while out_ready is held high and requests are present.
- Stall: with out_ready low and out_valid high, out_data, out_sel and p are frozen, and no in_ready is asserted.

## Structure
- Shared package mux_pkg:
  - typedef enum arb_mode_e {ARB_FIXED, ARB_RR}
  - localparam MAX_CH = 16
- Sub-module rr_arbiter: combinational grant from request vector and pointer, with parameters NUM_CH and ARB_MODE. Outputs are a one-hot grant, the encoded index and any_req.
- Top level contains the output register, pointer register, ready generation and the data mux.
- Elaboration-time check: 2 <= NUM_CH <= MAX_CH.

## Test plan
- Reset: hold rst_n low, drive in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0. Release rst_n -> first grant is to channel 0, p becomes 1.
- RR fairness: NUM_CH=4, all valid, out_ready=1, data k = 32'hA0+k -> out_sel sequence 0,1,2,3,0,... with out_data 32'hA0..32'hA3, one word per cycle, no bubbles.
- Fixed priority: ARB_FIXED, in_valid=4'b1010 held -> channel 1 granted every cycle. Channel 3 starves until ch1 valid drops, then channel 3 is granted.
- Backpressure: one word in register, out_ready=0 for 5 cycles with all valid -> in_ready=0 and outputs stable for those 5 cycles. out_ready=1 -> next word loads on the same edge.
- Wrap/idle: RR, only channel 3 valid -> grant 3, p wraps to 0. Then only channel 2 valid -> grant 2. Idle cycle -> out_valid=0, p unchanged.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n low -> out_valid=0 immediately (asynchronous) and p=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and limits for the arbitrated N-channel output multiplexer.
package mux_pkg;

   typedef enum logic {
      ARB_FIXED,
      ARB_RR
   } arb_mode_e;

   localparam int MAX_CH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester, either lowest index first or
// starting the search at a rotating pointer.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int        NUM_CH   = 4,
   parameter arb_mode_e ARB_MODE = ARB_RR,
   localparam int       SEL_W    = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              any_req
);

   logic [SEL_W-1:0] start;
   logic             found;

   assign start   = (ARB_MODE == ARB_FIXED) ? '0 : ptr;
   assign any_req = |req;

   // Walk the channels from the start index, wrapping, and keep the first hit.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int off = 0; off < NUM_CH; off++) begin
         int idx;
         idx = int'(start) + off;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = SEL_W'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with internal arbitration and a single
// registered output stage that can load a new word while the old one drains.
module mux_arb_n
   import mux_pkg::*;
#(
   parameter int        BUS_WIDTH = 32,
   parameter int        NUM_CH    = 4,
   parameter arb_mode_e ARB_MODE  = ARB_RR,
   localparam int       SEL_W     = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]           in_valid,
   output logic [NUM_CH-1:0]           in_ready,
   output logic [BUS_WIDTH-1:0]        out_data,
   output logic                        out_valid,
   output logic [SEL_W-1:0]            out_sel,
   input  logic                        out_ready
);

   if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("mux_arb_n: NUM_CH must lie in 2..%0d", MAX_CH);
   end

   logic [SEL_W-1:0]     ptr;
   logic [NUM_CH-1:0]    grant;
   logic [SEL_W-1:0]     grant_idx;
   logic                 any_req;
   logic                 free;
   logic [BUS_WIDTH-1:0] win_data;

   rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign free     = !out_valid || out_ready;
   assign in_ready = (free && rst_n) ? grant : '0;

   // One-hot AND-OR select avoids a variable part-select on the wide bus.
   always_comb begin
      win_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (grant[k]) win_data = win_data | in_data[k*BUS_WIDTH +: BUS_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (free) begin
         if (any_req) begin
            out_data  <= win_data;
            out_sel   <= grant_idx;
            out_valid <= 1'b1;
            ptr       <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: one round-robin and one fixed-priority instance.
module tb_mux_arb_n;
   import mux_pkg::*;

   localparam int W = 32;
   localparam int N = 4;

   logic             clk;
   logic             rst_n;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     valid_rr, valid_fx;
   logic [N-1:0]     ready_rr, ready_fx;
   logic [W-1:0]     data_rr, data_fx;
   logic             ovalid_rr, ovalid_fx;
   logic [1:0]       sel_rr, sel_fx;
   logic             ordy_rr, ordy_fx;

   int checks   = 0;
   int failures = 0;

   mux_arb_n #(.BUS_WIDTH(W), .NUM_CH(N), .ARB_MODE(ARB_RR)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(valid_rr),
      .in_ready(ready_rr), .out_data(data_rr), .out_valid(ovalid_rr),
      .out_sel(sel_rr), .out_ready(ordy_rr)
   );

   mux_arb_n #(.BUS_WIDTH(W), .NUM_CH(N), .ARB_MODE(ARB_FIXED)) dut_fx (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(valid_fx),
      .in_ready(ready_fx), .out_data(data_fx), .out_valid(ovalid_fx),
      .out_sel(sel_fx), .out_ready(ordy_fx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves the bench at a falling edge with reset just released.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      valid_rr = '0;
      valid_fx = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      valid_rr = 4'b1111;
      valid_fx = 4'b1111;
      ordy_rr  = 1'b1;
      ordy_fx  = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (ready_rr !== 4'b0000) begin failures++; $display("FAIL reset_ready_rr got=%b exp=0000", ready_rr); end
      checks++; if (ready_fx !== 4'b0000) begin failures++; $display("FAIL reset_ready_fx got=%b exp=0000", ready_fx); end
      checks++; if (ovalid_rr !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ovalid_rr); end
      checks++; if (data_rr !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", data_rr); end
      checks++; if (sel_rr !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0d exp=0", sel_rr); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (ready_rr !== 4'b0001) begin failures++; $display("FAIL release_ready_rr got=%b exp=0001", ready_rr); end
      checks++; if (ready_fx !== 4'b0001) begin failures++; $display("FAIL release_ready_fx got=%b exp=0001", ready_fx); end
      @(negedge clk);
      checks++; if (ovalid_rr !== 1'b1 || sel_rr !== 2'd0 || data_rr !== 32'hA0) begin
         failures++; $display("FAIL first_grant got=v%b s%0d d%h exp=v1 s0 d000000a0", ovalid_rr, sel_rr, data_rr);
      end
      #1;
      checks++; if (ready_rr !== 4'b0010) begin failures++; $display("FAIL ptr_after_first got=%b exp=0010", ready_rr); end
   endtask

   task automatic test_rr_fairness();
      logic [3:0]  exp_rdy;
      logic [31:0] exp_data;
      do_reset();
      valid_rr = 4'b1111;
      ordy_rr  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_rdy  = 4'b0001 << (i % 4);
         exp_data = 32'hA0 + 32'(i % 4);
         #1;
         checks++; if (ready_rr !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, ready_rr, exp_rdy); end
         @(negedge clk);
         checks++; if (ovalid_rr !== 1'b1 || sel_rr !== 2'(i % 4) || data_rr !== exp_data) begin
            failures++; $display("FAIL rr_out[%0d] got=v%b s%0d d%h exp=v1 s%0d d%h", i, ovalid_rr, sel_rr, data_rr, i % 4, exp_data);
         end
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      valid_fx = 4'b1010;
      ordy_fx  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (ready_fx !== 4'b0010) begin failures++; $display("FAIL fx_ready[%0d] got=%b exp=0010", i, ready_fx); end
         @(negedge clk);
         checks++; if (ovalid_fx !== 1'b1 || sel_fx !== 2'd1 || data_fx !== 32'hA1) begin
            failures++; $display("FAIL fx_out[%0d] got=v%b s%0d d%h exp=v1 s1 d000000a1", i, ovalid_fx, sel_fx, data_fx);
         end
      end
      valid_fx = 4'b1000;
      #1;
      checks++; if (ready_fx !== 4'b1000) begin failures++; $display("FAIL fx_ready_ch3 got=%b exp=1000", ready_fx); end
      @(negedge clk);
      checks++; if (ovalid_fx !== 1'b1 || sel_fx !== 2'd3 || data_fx !== 32'hA3) begin
         failures++; $display("FAIL fx_out_ch3 got=v%b s%0d d%h exp=v1 s3 d000000a3", ovalid_fx, sel_fx, data_fx);
      end
      valid_fx = '0;
   endtask

   task automatic test_backpressure();
      do_reset();
      valid_rr = 4'b1111;
      ordy_rr  = 1'b1;
      @(negedge clk);
      ordy_rr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (ready_rr !== 4'b0000) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=0000", i, ready_rr); end
         @(negedge clk);
         checks++; if (ovalid_rr !== 1'b1 || sel_rr !== 2'd0 || data_rr !== 32'hA0) begin
            failures++; $display("FAIL stall_out[%0d] got=v%b s%0d d%h exp=v1 s0 d000000a0", i, ovalid_rr, sel_rr, data_rr);
         end
      end
      ordy_rr = 1'b1;
      #1;
      checks++; if (ready_rr !== 4'b0010) begin failures++; $display("FAIL unstall_ready got=%b exp=0010", ready_rr); end
      @(negedge clk);
      checks++; if (ovalid_rr !== 1'b1 || sel_rr !== 2'd1 || data_rr !== 32'hA1) begin
         failures++; $display("FAIL unstall_out got=v%b s%0d d%h exp=v1 s1 d000000a1", ovalid_rr, sel_rr, data_rr);
      end
   endtask

   task automatic test_wrap_idle();
      do_reset();
      ordy_rr  = 1'b1;
      valid_rr = 4'b1000;
      #1;
      checks++; if (ready_rr !== 4'b1000) begin failures++; $display("FAIL wrap_ready_ch3 got=%b exp=1000", ready_rr); end
      @(negedge clk);
      checks++; if (sel_rr !== 2'd3 || data_rr !== 32'hA3) begin failures++; $display("FAIL wrap_out_ch3 got=s%0d d%h exp=s3 d000000a3", sel_rr, data_rr); end
      valid_rr = 4'b0101;
      #1;
      checks++; if (ready_rr !== 4'b0001) begin failures++; $display("FAIL wrap_ptr_zero got=%b exp=0001", ready_rr); end
      @(negedge clk);
      valid_rr = 4'b0100;
      #1;
      checks++; if (ready_rr !== 4'b0100) begin failures++; $display("FAIL wrap_ready_ch2 got=%b exp=0100", ready_rr); end
      @(negedge clk);
      checks++; if (ovalid_rr !== 1'b1 || sel_rr !== 2'd2 || data_rr !== 32'hA2) begin
         failures++; $display("FAIL wrap_out_ch2 got=v%b s%0d d%h exp=v1 s2 d000000a2", ovalid_rr, sel_rr, data_rr);
      end
      valid_rr = 4'b0000;
      #1;
      checks++; if (ready_rr !== 4'b0000) begin failures++; $display("FAIL idle_ready got=%b exp=0000", ready_rr); end
      @(negedge clk);
      checks++; if (ovalid_rr !== 1'b0 || sel_rr !== 2'd2 || data_rr !== 32'hA2) begin
         failures++; $display("FAIL idle_out got=v%b s%0d d%h exp=v0 s2 d000000a2", ovalid_rr, sel_rr, data_rr);
      end
      valid_rr = 4'b1111;
      #1;
      checks++; if (ready_rr !== 4'b1000) begin failures++; $display("FAIL idle_ptr_hold got=%b exp=1000", ready_rr); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      valid_rr = 4'b1111;
      ordy_rr  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ordy_rr = 1'b0;
      #1;
      checks++; if (ovalid_rr !== 1'b1 || sel_rr !== 2'd1) begin failures++; $display("FAIL midstall_pre got=v%b s%0d exp=v1 s1", ovalid_rr, sel_rr); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ovalid_rr !== 1'b0 || data_rr !== 32'h0 || sel_rr !== 2'd0) begin
         failures++; $display("FAIL midstall_async got=v%b s%0d d%h exp=v0 s0 d00000000", ovalid_rr, sel_rr, data_rr);
      end
      checks++; if (ready_rr !== 4'b0000) begin failures++; $display("FAIL midstall_ready got=%b exp=0000", ready_rr); end
      @(negedge clk);
      rst_n   = 1'b1;
      ordy_rr = 1'b1;
      #1;
      checks++; if (ready_rr !== 4'b0001) begin failures++; $display("FAIL midstall_ptr got=%b exp=0001", ready_rr); end
      @(negedge clk);
   endtask

   initial begin
      in_data = '0;
      for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'hA0 + 32'(k);
      test_reset();
      test_rr_fairness();
      test_fixed_priority();
      test_backpressure();
      test_wrap_idle();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
